// File: rtl/prog_tie_bank.sv
// Serially loaded bank of programmable tie-off constants with shadow/commit transfer.
// Optional macro TIE_FAULT_INJ_EN adds a combinational stuck-at override on tie_o.
module prog_tie_bank #(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic             cfg_data,
  output logic             cfg_ready,
  input  logic             cfg_commit,
  output logic             cfg_so,
  output logic             busy,
  output logic             done,
`ifdef TIE_FAULT_INJ_EN
  input  logic             flt_en,
  input  logic [CNT_W-1:0] flt_idx,
  input  logic             flt_val,
`endif
  output logic [WIDTH-1:0] tie_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FULL  = 2'd2,
    S_APPLY = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [WIDTH-1:0]   r_shadow;
  logic [WIDTH-1:0]   w_shadow_shift;
  logic [WIDTH-1:0]   r_tie;
  logic [WIDTH-1:0]   w_tie;
  logic               r_so;
  logic               r_done;
  logic               r_busy;
  logic               r_ready;
  logic               w_accept;

  assign w_accept  = cfg_valid & r_ready;
  assign w_cnt_inc = r_cnt + 1'b1;

  // New bits enter at the top so channel 0 (sent first) ends up in bit 0.
  generate
    if (WIDTH == 1) begin : g_shift_one
      assign w_shadow_shift = cfg_data;
    end else begin : g_shift_many
      assign w_shadow_shift = {cfg_data, r_shadow[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_SHIFT: begin
        if (w_accept) begin
          w_state_nxt = (w_cnt_inc == CNT_W'(WIDTH)) ? S_FULL : S_SHIFT;
        end
      end
      S_FULL: begin
        if (cfg_commit) w_state_nxt = S_APPLY;
      end
      S_APPLY: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_so     <= 1'b0;
      r_tie    <= RESET_VAL;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      // Flag outputs are decoded from the next state so they are flops, not state decode.
      r_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_SHIFT);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (r_state == S_APPLY);
      if (w_accept) begin
        r_shadow <= w_shadow_shift;
        r_so     <= r_shadow[0];
        r_cnt    <= w_cnt_inc;
      end
      if (r_state == S_APPLY) begin
        r_tie <= r_shadow;
        r_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_tie = r_tie;
`ifdef TIE_FAULT_INJ_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (flt_en && (flt_idx == CNT_W'(i))) w_tie[i] = flt_val;
    end
`endif
  end

  assign cfg_ready = r_ready;
  assign cfg_so    = r_so;
  assign busy      = r_busy;
  assign done      = r_done;
  assign tie_o     = w_tie;

endmodule
